// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner and fetch stage with 2-entry skid buffer ahead of the decode handshake.
// Optional macro IFETCH_PERF_EN adds fetch_count/stall_count performance counters.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [31:0] pc,
  input  logic [31:0] insn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_insn
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] buf_pc_q [2];
  logic [31:0] buf_pc_d [2];
  logic [31:0] buf_insn_q [2];
  logic [31:0] buf_insn_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;

  logic pop;
  logic push;
  logic issue;

  always_comb begin
    pop   = (count_q != 2'd0) & out_ready;
    push  = inflight_q;
    // Occupancy after this edge must leave room for the word this issue brings back.
    issue = run & ~redirect_valid &
            (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    buf_pc_d      = buf_pc_q;
    buf_insn_d    = buf_insn_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (redirect_valid) begin
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
      inflight_d = 1'b0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      count_d    = 2'd0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 32'd4;
      end
      if (push) begin
        buf_pc_d[wr_ptr_q]   = inflight_pc_q;
        buf_insn_d[wr_ptr_q] = insn;
        wr_ptr_d             = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      buf_pc_q[0]   <= 32'd0;
      buf_pc_q[1]   <= 32'd0;
      buf_insn_q[0] <= 32'd0;
      buf_insn_q[1] <= 32'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      buf_pc_q      <= buf_pc_d;
      buf_insn_q    <= buf_insn_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  assign pc        = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = buf_pc_q[rd_ptr_q];
  assign out_insn  = buf_insn_q[rd_ptr_q];

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q + {31'd0, issue};
    stall_count_d = stall_count_q + {31'd0, run & ~issue & ~redirect_valid};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed vector bench for instruction_fetch with a 1-cycle-latency memory model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        out_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] pc, insn, out_pc, out_insn;
  logic        out_valid;

  logic [31:0] pc2, insn2, out_pc2, out_insn2;
  logic        out_valid2;
  logic        run2 = 1'b1;
  logic        rdy2 = 1'b1;
  logic        rv2 = 1'b0;
  logic [31:0] rpc2 = 32'd0;

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count, stall_count;
  logic [31:0] fetch_count2, stall_count2;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  always @(posedge clk) begin
    insn  <= mem_word(pc);
    insn2 <= mem_word(pc2);
  end

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .run(run), .pc(pc), .insn(insn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_insn(out_insn)
`ifdef IFETCH_PERF_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .run(run2), .pc(pc2), .insn(insn2),
    .redirect_valid(rv2), .redirect_pc(rpc2),
    .out_valid(out_valid2), .out_ready(rdy2), .out_pc(out_pc2), .out_insn(out_insn2)
`ifdef IFETCH_PERF_EN
    , .fetch_count(fetch_count2), .stall_count(stall_count2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        run;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] efpc;
    logic [31:0] eopc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic r, input logic rdy, input logic rv,
                     input logic [31:0] rpc, input logic ev, input logic [31:0] efpc,
                     input logic [31:0] eopc);
    vec_t v;
    v.rst = rst; v.run = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.efpc = efpc; v.eopc = eopc;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] wrap_exp [4];
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    wrap_exp[3] = 32'h0000_0004;

    // streaming with out_ready=1
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    add(0, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    add(0, 1, 1, 0, 0, 0, 32'h4, 32'h0);
    add(0, 1, 1, 0, 0, 1, 32'h8, 32'h0);
    add(0, 1, 1, 0, 0, 1, 32'hC, 32'h4);
    add(0, 1, 1, 0, 0, 1, 32'h10, 32'h8);
    // backpressure for 5 cycles from the first valid, then release
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    add(0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    add(0, 1, 0, 0, 0, 0, 32'h4, 32'h0);
    add(0, 1, 0, 0, 0, 1, 32'h8, 32'h0);
    add(0, 1, 0, 0, 0, 1, 32'h8, 32'h0);
    add(0, 1, 0, 0, 0, 1, 32'h8, 32'h0);
    add(0, 1, 0, 0, 0, 1, 32'h8, 32'h0);
    add(0, 1, 0, 0, 0, 1, 32'h8, 32'h0);
    add(0, 1, 1, 0, 0, 1, 32'h8, 32'h0);
    add(0, 1, 1, 0, 0, 1, 32'hC, 32'h4);
    add(0, 1, 1, 0, 0, 1, 32'h10, 32'h8);
    add(0, 1, 1, 0, 0, 1, 32'h14, 32'hC);
    // redirect to 0x103 with the buffer full
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    add(0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    add(0, 1, 0, 0, 0, 0, 32'h4, 32'h0);
    add(0, 1, 0, 0, 0, 1, 32'h8, 32'h0);
    add(0, 1, 0, 0, 0, 1, 32'h8, 32'h0);
    add(0, 1, 0, 1, 32'h103, 1, 32'h8, 32'h0);
    add(0, 1, 1, 0, 0, 0, 32'h100, 32'h0);
    add(0, 1, 1, 0, 0, 0, 32'h104, 32'h0);
    add(0, 1, 1, 0, 0, 1, 32'h108, 32'h100);
    add(0, 1, 1, 0, 0, 1, 32'h10C, 32'h104);
    // redirect coinciding with a pop, run=0 holds off fetching
    add(0, 0, 1, 1, 32'h200, 1, 32'h110, 32'h108);
    add(0, 0, 1, 0, 0, 0, 32'h200, 32'h0);
    add(0, 0, 1, 0, 0, 0, 32'h200, 32'h0);
    add(0, 1, 1, 0, 0, 0, 32'h200, 32'h0);
    add(0, 1, 1, 0, 0, 0, 32'h204, 32'h0);
    add(0, 1, 0, 0, 0, 1, 32'h208, 32'h200);
    add(0, 1, 0, 0, 0, 1, 32'h208, 32'h200);
    // reset with a full buffer, then restart at RESET_PC
    add(1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    add(0, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    add(0, 1, 1, 0, 0, 0, 32'h4, 32'h0);
    add(0, 1, 1, 0, 0, 1, 32'h8, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset          = vecs[i].rst;
      run            = vecs[i].run;
      out_ready      = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      @(negedge clk);
      chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d pc", i), pc, vecs[i].efpc);
      if (vecs[i].ev || vecs[i].rst) begin
        chk($sformatf("v%0d out_pc", i), out_pc, vecs[i].eopc);
        chk($sformatf("v%0d out_insn", i), out_insn,
            vecs[i].rst ? 32'd0 : mem_word(vecs[i].eopc));
      end
    end

    // wrap-around instance and counters after a fresh reset
    @(posedge clk);
    #1;
    reset = 1'b1;
    run = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap reset pc", pc2, 32'hFFFF_FFF8);
`ifdef IFETCH_PERF_EN
    chk("perf reset fetch_count", fetch_count, 32'd0);
    chk("perf reset stall_count", stall_count, 32'd0);
`endif
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
      out_ready = (k == 6 || k == 7) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (k >= 2 && k <= 5) begin
        chk($sformatf("wrap c%0d out_valid", k), {31'd0, out_valid2}, 32'd1);
        chk($sformatf("wrap c%0d out_pc", k), out_pc2, wrap_exp[k-2]);
        chk($sformatf("wrap c%0d out_insn", k), out_insn2, mem_word(wrap_exp[k-2]));
      end
`ifdef IFETCH_PERF_EN
      if (k == 5) chk("perf fetch_count after 5", fetch_count, 32'd5);
      if (k == 8) begin
        chk("perf fetch_count after stall", fetch_count, 32'd6);
        chk("perf stall_count", stall_count, 32'd2);
      end
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
